processor_datapath: RTL
=======================

Name: processor_datapath

Overview:
- Datapath and sequencing stage directly downstream of the processor controller. It consumes every control strobe the controller produces and feeds back the instruction register contents and the timestep count that the controller decodes.
- Contains:
  - 2-bit timestep counter
  - 10-bit instruction register
  - 4x10-bit register file
  - operand latches A and G
  - 10-bit ALU
  - shared-bus source mux
- All storage is clocked on one edge.

Parameters:
- WIDTH, 10, datapath and bus width in bits. Fixed at 10; the instruction encoding depends on it.
- NREGS, 4, number of general registers. Fixed at 4 because Rin/Rout are 2-bit.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active low
- data  input  10  external data: instruction word or load operand
- IMM  input  10  immediate value from controller
- Rin  input  2  register-file write address
- Rout  input  2  register-file read address
- ENW  input  1  register-file write enable
- ENR  input  1  register-file read, drive bus
- Ain  input  1  load A from bus
- Gin  input  1  load G from bus
- Gout  input  1  drive ALU result onto bus
- ALUcont  input  4  ALU operation select
- Ext  input  1  drive bus from data
- IRin  input  1  load IR from bus
- Clr  input  1  clear timestep counter
- IR  output  10  instruction register
- timestep  output  2  current timestep
- bus  output  10  shared data bus value (combinational)
- regs  output  40  register file contents {R3,R2,R1,R0}, for debug/verification

Behaviour:
- Reset: synchronous, active low, sampled on the rising edge of clk. While rst_n=0 at an edge, the following all become 0 on that edge: timestep, IR, R0..R3, A, G. Reset mid-instruction abandons it; the first cycle after release is timestep 0.
- Bus mux (combinational, fixed priority):
  - Ext → data
  - else ENR → R[Rout]
  - else Gout → alu_result
  - else IMM
- IMM is the default source; the controller drives it only in cycles where no other source strobe is active.
- Timestep counter:
  - Clr=1 → 0 at the next edge.
  - Otherwise increments, wrapping 3→0.
  - Clr has priority over increment.
- IR: loads bus at the edge when IRin=1, otherwise holds.
- A and G: each loads bus at the edge when its enable is 1, otherwise holds. Both may load in the same cycle.
- Register file:
  - At an edge with ENW=1, R[Rin] ← bus.
  - Reads are combinational, so a same-cycle read of the register being written returns the old value. Example: copy Rx←Rx leaves Rx unchanged.
  - At most one write per cycle.
- ALU: combinational on A and G, result = f(A,G) truncated to 10 bits. Only meaningful when Gout=1; when Gout=0 ALUcont may be undriven, so alu_result must never affect state.

ALU operation table:
- 0010 ADD: A+G
- 0011 SUB: A−G, two's complement
- 0100 AND
- 0101 OR
- 0110 XOR
- 0111 NAND
- 1000 SLL: A << G[3:0]; shift ≥10 gives 0
- 1001 SRL: logical right shift, same rule
- 1010 SRA: arithmetic right shift; shift ≥10 gives all copies of A[9]
- 1011 SLT: 1 if signed A < signed G, else 0
- All other codes: 0

Overflow and carry are discarded; there are no flags.

Instruction sequences produced with the controller:
- Fetch (t0): bus=data, IR←data, counter advances.
- Load: value appears on bus at t1 and is written to R[IR[9:8]]; counter clears.
- ALU instruction: A←Rx (t1), G←Ry (t2), Rx←A op G (t3).
- Immediate: G←Rx (t1), A←IMM (t2), Rx←A+G (t3).
- Total latency: 2 cycles for load/copy, 4 cycles for ALU/immediate.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with Ext=1, IRin=1, data=10'h3FF → IR=0, timestep=0, regs=0. Release → timestep counts 0,1,2,3,0 with Clr=0.
- Load: t0 data=10'b01_00_0000_00 with IRin, Ext; t1 data=10'h155 with Ext, ENW, Rin=1, Clr → R1=10'h155, timestep=0.
- ALU ADD: R0=10'h3F0, R1=10'h020; strobes A←R0, G←R1, Gout with ALUcont=0010, ENW, Rin=0 → R0=10'h010 (wraps); R1 unchanged.
- Shifts/compare:
  - A=10'h200, G=3, SRA → 10'h3C0
  - SRL → 10'h040
  - G=12, SLL → 0
  - SLT A=10'h3FF, G=1 → 1
- Immediate subtract: R2=10'h005, G←R2, A←IMM=10'h3FE, ADD → R2=10'h003.
- Mid-op reset and bus priority:
  - Ext=1, ENR=1 with data=10'h0AA → bus=10'h0AA.
  - Assert rst_n=0 at timestep 2 of an ALU instruction → no register write; timestep=0, A=G=0 next cycle.

Source files
------------

// File: rtl/processor_datapath.sv
// rtl/processor_datapath.sv - datapath: timestep counter, IR, register file, A/G latches, ALU, bus mux
module processor_datapath #(
    parameter int WIDTH = 10,
    parameter int NREGS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         data,
    input  logic [WIDTH-1:0]         IMM,
    input  logic [1:0]               Rin,
    input  logic [1:0]               Rout,
    input  logic                     ENW,
    input  logic                     ENR,
    input  logic                     Ain,
    input  logic                     Gin,
    input  logic                     Gout,
    input  logic [3:0]               ALUcont,
    input  logic                     Ext,
    input  logic                     IRin,
    input  logic                     Clr,
    output logic [WIDTH-1:0]         IR,
    output logic [1:0]               timestep,
    output logic [WIDTH-1:0]         bus,
    output logic [NREGS*WIDTH-1:0]   regs
);

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NAND = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;

    logic [1:0]       timestep_q, timestep_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rf_d [NREGS];
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       shamt;
    logic             shift_out;

    // ALU on the operand latches; shift amounts of WIDTH or more flush the operand
    always_comb begin
        alu_result = '0;
        shamt      = g_q[3:0];
        shift_out  = (shamt >= 4'(WIDTH));
        case (ALUcont)
            OP_ADD:  alu_result = a_q + g_q;
            OP_SUB:  alu_result = a_q - g_q;
            OP_AND:  alu_result = a_q & g_q;
            OP_OR:   alu_result = a_q | g_q;
            OP_XOR:  alu_result = a_q ^ g_q;
            OP_NAND: alu_result = ~(a_q & g_q);
            OP_SLL:  alu_result = shift_out ? '0 : (a_q << shamt);
            OP_SRL:  alu_result = shift_out ? '0 : (a_q >> shamt);
            OP_SRA:  alu_result = shift_out ? {WIDTH{a_q[WIDTH-1]}}
                                            : WIDTH'($signed(a_q) >>> shamt);
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(g_q))};
            default: alu_result = '0;
        endcase
    end

    // Shared bus: fixed-priority source select, IMM when no other source strobe is active
    always_comb begin
        if (Ext) begin
            bus = data;
        end else if (ENR) begin
            bus = rf_q[Rout];
        end else if (Gout) begin
            bus = alu_result;
        end else begin
            bus = IMM;
        end
    end

    // Next-state for counter, IR, operand latches and register file; reads see pre-edge values
    always_comb begin
        timestep_d = Clr ? 2'd0 : timestep_q + 2'd1;
        ir_d       = IRin ? bus : ir_q;
        a_d        = Ain ? bus : a_q;
        g_d        = Gin ? bus : g_q;
        for (int i = 0; i < NREGS; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (ENW) begin
            rf_d[Rin] = bus;
        end
    end

    // All storage on the rising edge; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timestep_q <= 2'd0;
            ir_q       <= '0;
            a_q        <= '0;
            g_q        <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            timestep_q <= timestep_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            g_q        <= g_d;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Flatten the register file for observation as {R3,R2,R1,R0}
    always_comb begin
        regs = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs[i*WIDTH +: WIDTH] = rf_q[i];
        end
    end

    assign IR       = ir_q;
    assign timestep = timestep_q;

endmodule
